tdc_result_fifo: RTL and testbench
==================================

// Module: tdc_result_fifo
// PURPOSE
//  Downstream of the TDC core. Detects the end of each TDC measurement from its
//  asynchronous busy flag and captures coarse/fine results into 48-bit frames.
//  Frames go into a small FIFO and are handed to the SPI readout block over a
//  valid/ready interface.
// PARAMETERS
//  DEPTH     8    FIFO depth in frames (power of 2, >=2)
//  FINE_MAX  286  largest legal fine code; larger values set the frame error bit
// PORTS
//  clk          in   1   system clock (same clk as the TDC core)
//  rst          in   1   synchronous, active-high reset
//  tdc_busy     in   1   TDC busy flag, asynchronous to clk
//  tdc_coarse   in   32  TDC coarse result, stable once busy is low
//  tdc_fine     in   9   TDC fine result, stable once busy is low
//  frame_data   out  48  head frame {seq[5:0], err, coarse[31:0], fine[8:0]}
//  frame_valid  out  1   head frame present
//  frame_ready  in   1   consumer accepts the head frame on valid&&ready
//  level        out  $clog2(DEPTH)+1  frames stored
//  overflow     out  1   sticky: a frame was dropped because the FIFO was full
//  ovf_clear    in   1   clears overflow
//  drop_count   out  8   dropped-frame counter (only with TDC_RESULT_DROPCNT_EN)
// BEHAVIOUR
//  - One clock clk; reset rst is synchronous and active-high.
//  - Reset: frame_valid=0, frame_data=0, level=0, overflow=0, seq=0, drop_count=0.
//    All state, including partly-synchronised busy, is cleared on reset.
//  - tdc_busy passes through a 2-FF synchroniser, then a third flop for edge
//    detection.
//  - Capture event: the synchronised busy goes 1->0. Inputs are sampled in the
//    same cycle as the edge detect, 3 clk cycles after the asynchronous fall.
//    The TDC results have been stable since before busy fell.
//  - Frame fields:
//    - fine = tdc_fine.
//    - coarse = tdc_coarse.
//    - err = (tdc_fine > FINE_MAX).
//    - seq = 6-bit counter. It increments on every capture event, including
//      dropped frames, and wraps 63->0. A gap in seq at the consumer means frames
//      were lost.
//  - FIFO is first-word-fall-through:
//    - A push into an empty FIFO gives frame_valid=1 on the next cycle.
//    - frame_data holds steady while valid && !ready.
//  - Pop happens when frame_valid && frame_ready.
//  - Push and pop in the same cycle:
//    - level is unchanged.
//    - When full, the pop frees a slot first, so the push is accepted (no drop).
//  - Full with no pop: the new frame is discarded, overflow is set, and seq still
//    advances.
//  - ovf_clear in the same cycle as a new drop: the set wins (overflow stays 1).
//  - Rising edges of busy and busy held high cause no action. A busy pulse shorter
//    than 2 clk periods may be missed; this is an accepted limitation.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are
//    derived from level.
// CONFIGURATION
//  - TDC_RESULT_DROPCNT_EN defined: drop_count is an 8-bit saturating counter
//    (stops at 255). It increments on each dropped frame and clears on ovf_clear
//    or rst. A drop and ovf_clear in the same cycle gives drop_count=1.
//  - Not defined: the drop_count port is still present and tied to 0.
//    No counter logic is built.
// STRUCTURE
//  - Package tdc_pkg holds:
//    - FRAME_W=48, COARSE_W=32, FINE_W=9, SEQ_W=6.
//    - Field LSB offsets.
//    - Default FINE_MAX.
//    - typedef struct packed tdc_frame_t {seq, err, coarse, fine}.
//  - Sub-module: tdc_sync_2ff (generic 2-FF synchroniser with synchronous
//    reset). It is reused by the SPI block.
//  - Storage is a plain register array. No vendor RAM.
// TESTING
//  - Single capture:
//    - Stimulus: coarse=5, fine=17; busy high 10 cycles then low; ready=1.
//    - Expected: frame_valid high exactly 4 cycles after the fall, with
//      frame={0,0,5,17}. level returns to 0.
//  - Error flag: fine=287 -> err=1. fine=286 -> err=0.
//  - Overflow (DEPTH=8, ready=0):
//    - Stimulus: 10 measurements.
//    - Expected: level=8, overflow=1, drop_count=2 (EN). The head frame has
//      seq=0. After draining, the observed seq values are 0..7.
//  - Full with simultaneous pop: level=8, ready=1 in the capture cycle -> level
//    stays 8, overflow stays 0.
//  - Wrap and clear:
//    - 70 measurements with ready=1 -> seq goes 63 then 0.
//    - ovf_clear asserted in the same cycle as a drop -> overflow stays 1.
//  - Reset mid-operation: rst asserted with 3 frames stored and busy falling ->
//    level=0, valid=0, seq=0 next cycle, and no stray capture after release.

Source files
------------

// File: rtl/tdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : tdc_pkg                                                        |
// | Purpose   : Shared widths, field offsets and the frame record used by the  |
// |             TDC result path (result FIFO and SPI readout).                 |
// | Contents  : FRAME_W/COARSE_W/FINE_W/SEQ_W, field LSB offsets,              |
// |             FINE_MAX_DEFAULT, tdc_frame_t, fine_out_of_range().            |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package tdc_pkg;

  localparam int FRAME_W  = 48;
  localparam int COARSE_W = 32;
  localparam int FINE_W   = 9;
  localparam int SEQ_W    = 6;

  // Field LSB positions inside a frame {seq, err, coarse, fine}
  localparam int FINE_LSB   = 0;
  localparam int COARSE_LSB = FINE_LSB + FINE_W;
  localparam int ERR_BIT    = COARSE_LSB + COARSE_W;
  localparam int SEQ_LSB    = ERR_BIT + 1;

  localparam int FINE_MAX_DEFAULT = 286;

  typedef struct packed {
    logic [SEQ_W-1:0]    seq;
    logic                err;
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } tdc_frame_t;

  // A fine code above the interpolator's calibrated range marks the frame bad
  function automatic logic fine_out_of_range(input logic [FINE_W-1:0] fine,
                                             input logic [FINE_W-1:0] fine_max);
    return (fine > fine_max);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tdc_sync_2ff                                                   |
// | Purpose   : Generic two-flop synchroniser for level signals crossing into  |
// |             clk. Shared between the result FIFO and the SPI readout.       |
// | Parameters: WIDTH - number of independent bits synchronised                |
// | Ports     : clk  in  1      destination clock                              |
// |             rst  in  1      synchronous, active-high reset                 |
// |             i_d  in  WIDTH  asynchronous input                             |
// |             o_q  out WIDTH  synchronised output (2 clk latency)            |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tdc_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tdc_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tdc_result_fifo                                                |
// | Purpose   : Detects the end of each TDC measurement from the asynchronous  |
// |             busy flag, captures coarse/fine results into 48-bit frames     |
// |             and queues them in a first-word-fall-through FIFO for readout. |
// | Parameters: DEPTH    - FIFO depth in frames (power of 2, >= 2)             |
// |             FINE_MAX - largest legal fine code                             |
// | Macro     : TDC_RESULT_DROPCNT_EN - builds the saturating drop counter;    |
// |             when undefined drop_count is tied to zero.                     |
// | Ports     : clk          in   1   system clock                             |
// |             rst          in   1   synchronous, active-high reset           |
// |             tdc_busy     in   1   TDC busy flag (asynchronous)             |
// |             tdc_coarse   in   32  coarse result, stable while busy low     |
// |             tdc_fine     in   9   fine result, stable while busy low       |
// |             frame_data   out  48  head frame {seq, err, coarse, fine}      |
// |             frame_valid  out  1   head frame present                       |
// |             frame_ready  in   1   consumer takes head on valid && ready    |
// |             level        out  L   frames stored, L = $clog2(DEPTH)+1       |
// |             overflow     out  1   sticky frame-dropped flag                |
// |             ovf_clear    in   1   clears overflow (and drop_count)         |
// |             drop_count   out  8   saturating dropped-frame count           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tdc_result_fifo
  import tdc_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int FINE_MAX = FINE_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tdc_busy,
  input  logic [COARSE_W-1:0]      tdc_coarse,
  input  logic [FINE_W-1:0]        tdc_fine,
  output logic [FRAME_W-1:0]       frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clear,
  output logic [7:0]               drop_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);
  localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
  localparam logic [SEQ_W-1:0]   c_SEQ_ONE  = SEQ_W'(1);
  localparam logic [FINE_W-1:0]  c_FINE_MAX = FINE_W'(FINE_MAX);

  // ---------------------------------------------------------------------------
  // Busy synchronisation and falling-edge detect
  // ---------------------------------------------------------------------------
  logic w_busy_sync;
  logic r_busy_dly;
  logic w_busy_fall;

  tdc_sync_2ff #(
    .WIDTH (1)
  ) u_busy_sync (
    .clk (clk),
    .rst (rst),
    .i_d (tdc_busy),
    .o_q (w_busy_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_dly <= 1'b0;
    end else begin
      r_busy_dly <= w_busy_sync;
    end
  end

  assign w_busy_fall = r_busy_dly & ~w_busy_sync;

  // ---------------------------------------------------------------------------
  // Capture stage: results are sampled on the edge that sees the busy fall.
  // The sequence number is consumed here so dropped frames still leave a gap.
  // ---------------------------------------------------------------------------
  tdc_frame_t       w_new_frame;
  tdc_frame_t       r_cap_frame;
  logic             r_cap_vld;
  logic [SEQ_W-1:0] r_seq;

  always_comb begin
    w_new_frame        = '0;
    w_new_frame.seq    = r_seq;
    w_new_frame.err    = fine_out_of_range(tdc_fine, c_FINE_MAX);
    w_new_frame.coarse = tdc_coarse;
    w_new_frame.fine   = tdc_fine;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_vld   <= 1'b0;
      r_cap_frame <= '0;
      r_seq       <= '0;
    end else begin
      r_cap_vld <= w_busy_fall;
      if (w_busy_fall) begin
        r_cap_frame <= w_new_frame;
        r_seq       <= r_seq + c_SEQ_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  tdc_frame_t         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_LVL_FULL);
  assign w_pop   = !w_empty && frame_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts
  assign w_push  = r_cap_vld && (!w_full || w_pop);
  assign w_drop  = r_cap_vld && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_cap_frame;
        r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + c_LVL_ONE;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - c_LVL_ONE;
      end
    end
  end

  assign frame_valid = !w_empty;
  assign frame_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level       = r_level;

  // ---------------------------------------------------------------------------
  // Overflow reporting: a new drop takes priority over a clear request
  // ---------------------------------------------------------------------------
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clear) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

`ifdef TDC_RESULT_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (ovf_clear) begin
      // The clear restarts the count; a drop in the same cycle is its first
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdc_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_tdc_result_fifo                                             |
// | Purpose   : Self-checking bench for tdc_result_fifo. Expected frames are   |
// |             queued when a measurement ends and compared when the consumer  |
// |             pops them; table vectors cover fine/err encoding, hand         |
// |             sequences cover latency, overflow, wrap and reset.             |
// | Macro     : TDC_RESULT_DROPCNT_EN - selects expected drop_count values     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_tdc_result_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        tdc_busy;
  logic [31:0] tdc_coarse;
  logic [8:0]  tdc_fine;
  logic [47:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        ovf_clear;
  logic [7:0]  drop_count;

  tdc_result_fifo #(
    .DEPTH    (DEPTH),
    .FINE_MAX (286)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tdc_busy    (tdc_busy),
    .tdc_coarse  (tdc_coarse),
    .tdc_fine    (tdc_fine),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .level       (level),
    .overflow    (overflow),
    .ovf_clear   (ovf_clear),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [47:0] sb_q[$];
  logic [5:0]  exp_seq  = 6'd0;

  typedef struct {
    logic [31:0] coarse;
    logic [8:0]  fine;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: sample just after the negedge, once the bench's
  // drives for that half cycle have settled; a pop happens on the next posedge.
  initial begin
    logic [47:0] exp_frame;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && frame_valid && frame_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got frame 0x%0h, expected none", frame_data);
        end else begin
          exp_frame = sb_q.pop_front();
          check("sb_frame", frame_data, exp_frame);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One measurement; returns on the negedge after the frame would be pushed
  task automatic meas(input logic [31:0] c, input logic [8:0] f, input logic e, input bit drop);
    tdc_coarse = c;
    tdc_fine   = f;
    tdc_busy   = 1'b1;
    cyc(3);
    tdc_busy = 1'b0;
    if (!drop) sb_q.push_back({exp_seq, e, c, f});
    exp_seq++;
    cyc(4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    sb_q.delete();
    exp_seq = 6'd0;
    cyc(1);
  endtask

  task automatic drain(input string name);
    int budget;
    frame_ready = 1'b1;
    budget = 200;
    while (sb_q.size() != 0 && budget > 0) begin
      cyc(1);
      budget--;
    end
    cyc(1);
    check({name, "_drained"}, 48'(sb_q.size()), 48'd0);
    check({name, "_level0"}, 48'(level), 48'd0);
  endtask

  initial begin
    rst         = 1'b1;
    tdc_busy    = 1'b0;
    tdc_coarse  = '0;
    tdc_fine    = '0;
    frame_ready = 1'b0;
    ovf_clear   = 1'b0;

    vecs[0] = '{coarse: 32'd5,          fine: 9'd17,  exp_err: 1'b0};
    vecs[1] = '{coarse: 32'd0,          fine: 9'd286, exp_err: 1'b0};
    vecs[2] = '{coarse: 32'hFFFF_FFFF,  fine: 9'd287, exp_err: 1'b1};
    vecs[3] = '{coarse: 32'd123456,     fine: 9'd511, exp_err: 1'b1};
    vecs[4] = '{coarse: 32'h0000_0001,  fine: 9'd0,   exp_err: 1'b0};
    vecs[5] = '{coarse: 32'hDEAD_BEEF,  fine: 9'd200, exp_err: 1'b0};

    // Reset state
    cyc(3);
    check("rst_valid", 48'(frame_valid), 48'd0);
    check("rst_data", frame_data, 48'd0);
    check("rst_level", 48'(level), 48'd0);
    check("rst_ovf", 48'(overflow), 48'd0);
    check("rst_dropcnt", 48'(drop_count), 48'd0);
    rst = 1'b0;
    cyc(2);

    // Single capture: valid exactly 4 cycles after the fall
    frame_ready = 1'b1;
    tdc_coarse  = 32'd5;
    tdc_fine    = 9'd17;
    tdc_busy    = 1'b1;
    cyc(10);
    tdc_busy = 1'b0;
    sb_q.push_back({6'd0, 1'b0, 32'd5, 9'd17});
    exp_seq++;
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      check("single_early_valid", 48'(frame_valid), 48'd0);
    end
    cyc(1);
    check("single_valid", 48'(frame_valid), 48'd1);
    check("single_frame", frame_data, {6'd0, 1'b0, 32'd5, 9'd17});
    cyc(1);
    check("single_level", 48'(level), 48'd0);

    // Table vectors: err encoding around FINE_MAX
    for (int i = 0; i < 6; i++) begin
      meas(vecs[i].coarse, vecs[i].fine, vecs[i].exp_err, 1'b0);
      check("vec_err", 48'(frame_data[41]), 48'(vecs[i].exp_err));
      check("vec_fine", 48'(frame_data[8:0]), 48'(vecs[i].fine));
    end
    drain("vec");

    // Overflow: 10 measurements into a stalled FIFO, last two dropped
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      meas(32'(1000 + i), 9'(i * 3), 1'b0, i >= DEPTH);
    end
    check("ovf_level", 48'(level), 48'd8);
    check("ovf_flag", 48'(overflow), 48'd1);
`ifdef TDC_RESULT_DROPCNT_EN
    check("ovf_dropcnt", 48'(drop_count), 48'd2);
`else
    check("ovf_dropcnt", 48'(drop_count), 48'd0);
`endif
    check("ovf_head_seq", 48'(frame_data[47:42]), 48'd0);
    cyc(2);
    check("ovf_head_hold", frame_data, {6'd0, 1'b0, 32'd1000, 9'd0});
    drain("ovf");
    ovf_clear = 1'b1;
    cyc(1);
    ovf_clear = 1'b0;
    cyc(1);
    check("ovf_cleared", 48'(overflow), 48'd0);

    // Full with a simultaneous pop on the push cycle
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) meas(32'(2000 + i), 9'd50, 1'b0, 1'b0);
    tdc_coarse = 32'd2100;
    tdc_fine   = 9'd300;
    tdc_busy   = 1'b1;
    cyc(3);
    tdc_busy = 1'b0;
    sb_q.push_back({exp_seq, 1'b1, 32'd2100, 9'd300});
    exp_seq++;
    cyc(3);
    frame_ready = 1'b1;
    cyc(1);
    frame_ready = 1'b0;
    cyc(1);
    check("fullpop_level", 48'(level), 48'd8);
    check("fullpop_ovf", 48'(overflow), 48'd0);
    drain("fullpop");

    // ovf_clear coinciding with a drop: the set wins
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) meas(32'(3000 + i), 9'd1, 1'b0, 1'b0);
    tdc_busy = 1'b1;
    cyc(3);
    tdc_busy = 1'b0;
    exp_seq++;
    cyc(3);
    ovf_clear = 1'b1;
    cyc(1);
    ovf_clear = 1'b0;
    cyc(1);
    check("clrdrop_ovf", 48'(overflow), 48'd1);
`ifdef TDC_RESULT_DROPCNT_EN
    check("clrdrop_dropcnt", 48'(drop_count), 48'd1);
`else
    check("clrdrop_dropcnt", 48'(drop_count), 48'd0);
`endif
    drain("clrdrop");

    // Sequence wrap 63 -> 0 with a free-running consumer
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      meas(32'(i * 7), 9'(i), 1'b0, 1'b0);
      if (i == 63) check("wrap_seq63", 48'(frame_data[47:42]), 48'd63);
      if (i == 64) check("wrap_seq0", 48'(frame_data[47:42]), 48'd0);
    end
    drain("wrap");

    // Reset mid-operation with 3 frames stored and busy falling
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 3; i++) meas(32'(4000 + i), 9'd9, 1'b0, 1'b0);
    check("midrst_pre_level", 48'(level), 48'd3);
    tdc_busy = 1'b1;
    cyc(3);
    tdc_busy = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    sb_q.delete();
    exp_seq = 6'd0;
    check("midrst_level", 48'(level), 48'd0);
    check("midrst_valid", 48'(frame_valid), 48'd0);
    cyc(8);
    check("midrst_no_stray", 48'(level), 48'd0);
    frame_ready = 1'b1;
    meas(32'd77, 9'd7, 1'b0, 1'b0);
    check("midrst_seq0", 48'(frame_data[47:42]), 48'd0);
    drain("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
